kong_intro_anim: RTL and testbench
==================================

// Module: kong_intro_anim
// PURPOSE
//  Drives Kong's intro animation: climbs from the start spot to platform height,
//  walks left to the platform x, then does one jump arc and parks.
//  Produces the position that kong_pkg's constants describe (writer side); the Kong draw/sprite
//  block reads xpos/ypos. Sits in the game-control path, started by the game FSM.
// PARAMETERS
//  MOVE_TICKS  250_000    clk cycles per 1-px climb/walk step (kong_pkg::MOVE_TAKI_NIE_MACQUEEN)
//  JUMP_TICKS  1_400_000  clk cycles per 1-px jump step (kong_pkg::JUMP_TAKI_W_MIARE)
//  JUMP_H      58         jump apex height in px (kong_pkg::KONG_JUMP_HEIGHT)
//  X0 484, Y0 672         start position (KONG_ANIMATION_INITIAL_XPOS/YPOS)
//  XP 128, YP 175         platform position (KONG_PLATFORM_XPOS/YPOS)
// PORTS
//  clk          in   1   system clock
//  rst_n        in   1   async active-low reset
//  start        in   1   1-cycle pulse: begin animation (ignored while busy)
//  abort        in   1   sync: return to IDLE, position back to X0/Y0
//  xpos         out  12  Kong sprite x (top-left)
//  ypos         out  12  Kong sprite y (top-left)
//  frame        out  1   sprite frame select, toggles every 8 px of climb/walk
//  jumping      out  1   high in JUMP_UP/JUMP_DN
//  busy         out  1   high in any state except IDLE/DONE
//  done         out  1   high in DONE
// BEHAVIOUR
//  Reset (async assert, sync-free release): state IDLE, xpos=X0, ypos=Y0, frame=0,
//   tick cnt=0, jumping=0, busy=0, done=0. All outputs are registered.
//  Tick counter: counts 0..N-1 (N = MOVE_TICKS or JUMP_TICKS per state); one step on cnt==N-1,
//   then cnt wraps to 0. Cleared on every state change.
//   Width = $clog2(max(MOVE_TICKS,JUMP_TICKS)).
//  FSM:
//   IDLE    : start -> CLIMB next cycle (cnt=0). xpos/ypos reload X0/Y0 on entry.
//   CLIMB   : each step ypos-=1; at the step making ypos==YP -> WALK.
//   WALK    : each step xpos-=1; at the step making xpos==XP -> JUMP_UP.
//   JUMP_UP : each JUMP step ypos-=1; at ypos==YP-JUMP_H (117) -> JUMP_DN.
//   JUMP_DN : each JUMP step ypos+=1; at ypos==YP -> DONE.
//   DONE    : holds XP/YP, done=1. start -> re-enters CLIMB from X0/Y0 (same cycle reload).
//  frame: per-state 3-bit px counter; toggles when it wraps (every 8th step) in CLIMB/WALK.
//   Frozen in JUMP_*. Cleared in IDLE.
//  Step counts: climb 497, walk 356, jump 58 up + 58 down.
//   Total cycles start->done = 1 + (497+356)*MOVE_TICKS + 116*JUMP_TICKS.
//  abort (any state) has priority over start and over a step in the same cycle:
//   next cycle IDLE with X0/Y0, frame=0, flags low.
//  start while busy: no effect. start and abort together: abort wins.
//  Position never goes below YP-JUMP_H or outside [XP,X0]x[YP-JUMP_H,Y0]; arithmetic unsigned
//   12-bit, no wrap possible with the legal constants.
//  rst_n low mid-animation: immediate return to reset values; start needed after release.
// TESTING (MOVE_TICKS=2, JUMP_TICKS=3)
//  1 reset, no start for 100 cycles -> xpos=484, ypos=672, busy=0, done=0 throughout.
//  2 start pulse -> busy next cycle; ypos=671 after 3 cycles; WALK entered when ypos=175
//    (cycle 995); done=1 at cycle 1+1706+348=2055 with xpos=128, ypos=175.
//  3 monitor JUMP_UP -> ypos min exactly 117, jumping=1 only during 116 jump steps, frame constant.
//  4 abort at mid-WALK (xpos=300) -> next cycle IDLE, xpos=484, ypos=672, busy=0;
//    start asserted same cycle as abort is ignored.
//  5 start pulses during CLIMB -> no restart; start in DONE -> busy=1, xpos=484, ypos=672, done=0.
//  6 rst_n low during JUMP_DN -> outputs at reset values asynchronously; no motion until new start.

Source files
------------

// File: rtl/kong_intro_anim.sv
// Kong intro animation: climb to platform height, walk left to platform x,
// one jump arc, then park. All outputs registered.
module kong_intro_anim #(
  parameter int MOVE_TICKS = 250_000,
  parameter int JUMP_TICKS = 1_400_000,
  parameter int JUMP_H     = 58,
  parameter int X0         = 484,
  parameter int Y0         = 672,
  parameter int XP         = 128,
  parameter int YP         = 175
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  output logic [11:0] xpos,
  output logic [11:0] ypos,
  output logic        frame,
  output logic        jumping,
  output logic        busy,
  output logic        done
);

  localparam int TMAX = (MOVE_TICKS > JUMP_TICKS) ? MOVE_TICKS : JUMP_TICKS;
  localparam int CW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  localparam logic [CW-1:0] MOVE_LAST = CW'(MOVE_TICKS - 1);
  localparam logic [CW-1:0] JUMP_LAST = CW'(JUMP_TICKS - 1);
  localparam logic [11:0]   X0_V      = 12'(X0);
  localparam logic [11:0]   Y0_V      = 12'(Y0);
  localparam logic [11:0]   XP_V      = 12'(XP);
  localparam logic [11:0]   YP_V      = 12'(YP);
  localparam logic [11:0]   YTOP_V    = 12'(YP - JUMP_H);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLIMB,
    S_WALK,
    S_JUMP_UP,
    S_JUMP_DN,
    S_DONE
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [2:0]    px, px_nxt;
  logic [11:0]   x_nxt, y_nxt;
  logic          frame_nxt;
  logic          moving;
  logic          in_jump;
  logic          step;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      cnt     <= '0;
      px      <= '0;
      xpos    <= X0_V;
      ypos    <= Y0_V;
      frame   <= 1'b0;
      jumping <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      px      <= px_nxt;
      xpos    <= x_nxt;
      ypos    <= y_nxt;
      frame   <= frame_nxt;
      jumping <= (state_nxt == S_JUMP_UP) || (state_nxt == S_JUMP_DN);
      busy    <= (state_nxt != S_IDLE) && (state_nxt != S_DONE);
      done    <= (state_nxt == S_DONE);
    end
  end

  always_comb begin
    state_nxt = state;
    x_nxt     = xpos;
    y_nxt     = ypos;
    px_nxt    = px;
    frame_nxt = frame;

    in_jump = (state == S_JUMP_UP) || (state == S_JUMP_DN);
    moving  = (state == S_CLIMB) || (state == S_WALK) || in_jump;
    step    = moving && (cnt == (in_jump ? JUMP_LAST : MOVE_LAST));
    cnt_nxt = (moving && !step) ? cnt + 1'b1 : '0;

    case (state)
      S_IDLE: begin
        x_nxt     = X0_V;
        y_nxt     = Y0_V;
        px_nxt    = '0;
        frame_nxt = 1'b0;
        if (start) state_nxt = S_CLIMB;
      end
      S_CLIMB: begin
        if (step) begin
          y_nxt  = ypos - 12'd1;
          px_nxt = px + 3'd1;
          if (px == 3'd7) frame_nxt = ~frame;
          if (ypos - 12'd1 == YP_V) state_nxt = S_WALK;
        end
      end
      S_WALK: begin
        if (step) begin
          x_nxt  = xpos - 12'd1;
          px_nxt = px + 3'd1;
          if (px == 3'd7) frame_nxt = ~frame;
          if (xpos - 12'd1 == XP_V) state_nxt = S_JUMP_UP;
        end
      end
      S_JUMP_UP: begin
        if (step) begin
          y_nxt = ypos - 12'd1;
          if (ypos - 12'd1 == YTOP_V) state_nxt = S_JUMP_DN;
        end
      end
      S_JUMP_DN: begin
        if (step) begin
          y_nxt = ypos + 12'd1;
          if (ypos + 12'd1 == YP_V) state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (start) begin
          state_nxt = S_CLIMB;
          x_nxt     = X0_V;
          y_nxt     = Y0_V;
        end
      end
      default: state_nxt = S_IDLE;
    endcase

    // Pixel counter is per-state; frame itself carries across state changes.
    if (state_nxt != state) begin
      cnt_nxt = '0;
      px_nxt  = '0;
    end

    if (abort) begin
      state_nxt = S_IDLE;
      x_nxt     = X0_V;
      y_nxt     = Y0_V;
      px_nxt    = '0;
      frame_nxt = 1'b0;
      cnt_nxt   = '0;
    end
  end

endmodule

// File: tb/tb_kong_intro_anim.sv
// Bench for kong_intro_anim: hand-computed checkpoints, directed corner cases and
// random start/abort traffic against a closed-form position model.
module tb_kong_intro_anim;

  localparam int M        = 2;
  localparam int J        = 3;
  localparam int CLIMB_N  = 497;
  localparam int WALK_N   = 356;
  localparam int JUMP_N   = 58;
  localparam int MOVE_END = (CLIMB_N + WALK_N) * M;
  localparam int TOTAL    = MOVE_END + 2 * JUMP_N * J;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [11:0] xpos;
  logic [11:0] ypos;
  logic        frame;
  logic        jumping;
  logic        busy;
  logic        done;

  int checks   = 0;
  int failures = 0;

  // model: mode 0 idle, 1 animating (m_j cycles since start accepted), 2 parked
  int m_mode = 0;
  int m_j    = 0;

  typedef struct {
    int          j;
    logic [11:0] x;
    logic [11:0] y;
    logic        fr;
    logic        jp;
    logic        bs;
    logic        dn;
  } vec_t;

  vec_t tbl [13];

  kong_intro_anim #(.MOVE_TICKS(M), .JUMP_TICKS(J)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .abort   (abort),
    .xpos    (xpos),
    .ypos    (ypos),
    .frame   (frame),
    .jumping (jumping),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_out(output int ex, output int ey, output int ef,
                           output int ej, output int eb, output int ed);
    int s, w, js;
    ex = 484; ey = 672; ef = 0; ej = 0; eb = 0; ed = 0;
    if (m_mode == 1 && m_j < MOVE_END) begin
      s  = m_j / M;
      eb = 1;
      if (s < CLIMB_N) begin
        ey = 672 - s;
        ef = (s / 8) % 2;
      end else begin
        w  = s - CLIMB_N;
        ex = 484 - w;
        ey = 175;
        ef = (CLIMB_N / 8 + w / 8) % 2;
      end
    end else if (m_mode == 1) begin
      js = (m_j - MOVE_END) / J;
      ex = 128;
      ey = (js < JUMP_N) ? 175 - js : 117 + (js - JUMP_N);
      ef = (CLIMB_N / 8 + WALK_N / 8) % 2;
      ej = 1;
      eb = 1;
    end else if (m_mode == 2) begin
      ex = 128;
      ey = 175;
      ef = (CLIMB_N / 8 + WALK_N / 8) % 2;
      ed = 1;
    end
  endtask

  task automatic model_edge(input logic st, input logic ab);
    if (!rst_n || ab) begin
      m_mode = 0;
    end else if (st && m_mode != 1) begin
      m_mode = 1;
      m_j    = 0;
    end else if (m_mode == 1) begin
      m_j++;
      if (m_j >= TOTAL) m_mode = 2;
    end
  endtask

  task automatic compare_all(input string tag);
    int ex, ey, ef, ej, eb, ed;
    model_out(ex, ey, ef, ej, eb, ed);
    check({tag, ".xpos"},    int'(xpos),    ex);
    check({tag, ".ypos"},    int'(ypos),    ey);
    check({tag, ".frame"},   int'(frame),   ef);
    check({tag, ".jumping"}, int'(jumping), ej);
    check({tag, ".busy"},    int'(busy),    eb);
    check({tag, ".done"},    int'(done),    ed);
  endtask

  // Called at a negedge; applies inputs across one posedge and returns at the next negedge.
  task automatic cycle(input logic st, input logic ab);
    start = st;
    abort = ab;
    @(posedge clk);
    model_edge(st, ab);
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic hand(input string tag, input int x, input int y,
                      input int fr, input int jp, input int bs, input int dn);
    check({tag, ".xpos"},    int'(xpos),    x);
    check({tag, ".ypos"},    int'(ypos),    y);
    check({tag, ".frame"},   int'(frame),   fr);
    check({tag, ".jumping"}, int'(jumping), jp);
    check({tag, ".busy"},    int'(busy),    bs);
    check({tag, ".done"},    int'(done),    dn);
  endtask

  initial begin
    int k;
    tbl[0]  = '{0,    484, 672, 0, 0, 1, 0};
    tbl[1]  = '{2,    484, 671, 0, 0, 1, 0};
    tbl[2]  = '{16,   484, 664, 1, 0, 1, 0};
    tbl[3]  = '{994,  484, 175, 0, 0, 1, 0};
    tbl[4]  = '{996,  483, 175, 0, 0, 1, 0};
    tbl[5]  = '{1010, 476, 175, 1, 0, 1, 0};
    tbl[6]  = '{1704, 129, 175, 0, 0, 1, 0};
    tbl[7]  = '{1706, 128, 175, 0, 1, 1, 0};
    tbl[8]  = '{1709, 128, 174, 0, 1, 1, 0};
    tbl[9]  = '{1880, 128, 117, 0, 1, 1, 0};
    tbl[10] = '{1883, 128, 118, 0, 1, 1, 0};
    tbl[11] = '{2053, 128, 174, 0, 1, 1, 0};
    tbl[12] = '{2054, 128, 175, 0, 0, 0, 1};

    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    repeat (3) @(negedge clk);
    hand("reset", 484, 672, 0, 0, 0, 0);
    rst_n = 1'b1;

    // idle without start
    for (int i = 0; i < 100; i++) begin
      cycle(1'b0, 1'b0);
      compare_all("idle");
    end

    // full run with checkpoints; stray starts during the climb
    cycle(1'b1, 1'b0);
    k = 0;
    for (int j = 0; j <= TOTAL; j++) begin
      compare_all("run");
      if (k < 13 && tbl[k].j == j) begin
        hand($sformatf("vec%0d", k), tbl[k].x, tbl[k].y, tbl[k].fr,
             tbl[k].jp, tbl[k].bs, tbl[k].dn);
        k++;
      end
      if (j < TOTAL) cycle(j == 100 || j == 300, 1'b0);
    end
    check("vec_all_hit", k, 13);

    // start from DONE restarts immediately from the origin
    cycle(1'b1, 1'b0);
    hand("restart", 484, 672, 0, 0, 1, 0);

    // abort mid-walk with simultaneous start
    for (int i = 0; i < 1362; i++) cycle(1'b0, 1'b0);
    check("abort_pre.xpos", int'(xpos), 300);
    cycle(1'b1, 1'b1);
    hand("abort", 484, 672, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, 1'b0);
      compare_all("post_abort");
    end

    // async reset during descent
    cycle(1'b1, 1'b0);
    for (int i = 0; i < 1890; i++) cycle(1'b0, 1'b0);
    check("pre_rst.jumping", int'(jumping), 1);
    check("pre_rst.ypos", int'(ypos), 120);
    #1 rst_n = 1'b0;
    #1;
    m_mode = 0;
    hand("async_rst", 484, 672, 0, 0, 0, 0);
    @(negedge clk);
    cycle(1'b0, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cycle(1'b0, 1'b0);
      compare_all("post_rst");
    end

    // random start/abort traffic
    for (int i = 0; i < 20000; i++) begin
      cycle($urandom_range(0, 99) < 3, $urandom_range(0, 2999) == 0);
      compare_all("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
